mem_port_arbiter: RTL and testbench

Single-clock controller that shares one single-port memory array between two requesters, PORTA and PORTB. It arbitrates pending requests and holds the memory-side controls for the port's configured write or read latency. When the access completes it returns a one-cycle acknowledge, plus captured read data on reads. It sits between the two port-side drivers and the memory array, inside the memory controller.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter_lat_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default parameters for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package param;

  typedef enum logic {PORTA = 1'b0, PORTB = 1'b1} port;
  typedef enum logic {WR = 1'b0, RD = 1'b1} we_type;
  typedef enum logic {EN_OFF = 1'b0, EN_ON = 1'b1} en_type;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} arb_state_t;

  localparam int DEF_D_W = 8;
  localparam int DEF_A_W = 3;
  localparam int DEF_W_LAT [2] = '{5, 5};
  localparam int DEF_R_LAT [2] = '{6, 6};

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit above the longest latency so LAT-1 always fits.
  localparam int LAT_W = $clog2(max2(max2(DEF_W_LAT[0], DEF_W_LAT[1]),
                                     max2(DEF_R_LAT[0], DEF_R_LAT[1]))) + 1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundles of the two-port memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold en/we/addr/wdata until they see their ack.
interface arb_req_if #(
  parameter int D_W = param::DEF_D_W,
  parameter int A_W = param::DEF_A_W
);
  logic [1:0]          en;
  logic [1:0]          we;
  logic [1:0][A_W-1:0] addr;
  logic [1:0][D_W-1:0] wdata;
  logic [1:0]          ack;
  logic [1:0]          rvalid;
  logic [D_W-1:0]      rdata;
  logic                grant;
  logic                busy;

  modport master (output en, we, addr, wdata,
                  input  ack, rvalid, rdata, grant, busy);
  modport slave  (input  en, we, addr, wdata,
                  output ack, rvalid, rdata, grant, busy);
endinterface

interface arb_mem_if #(
  parameter int D_W = param::DEF_D_W,
  parameter int A_W = param::DEF_A_W
);
  logic           mem_en;
  logic           mem_we;
  logic [A_W-1:0] mem_addr;
  logic [D_W-1:0] mem_wdata;
  logic [D_W-1:0] mem_rdata;

  modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Access-length down-counter: load, decrement enable, zero flag.
// Latency: load/decrement visible the cycle after the edge; zero flag is combinational on the count.
// Backpressure: none; decrement saturates at zero.
module lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement; hold at zero once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between PORTA/PORTB; ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: request sampled in IDLE, mem_en high LAT cycles, ack/rvalid one cycle after (LAT+2 per access).
// Backpressure: a waiting requester holds en until its ack; an access never aborts once granted.
module mem_port_arbiter
  import param::*;
#(
  parameter int D_W       = DEF_D_W,
  parameter int A_W       = DEF_A_W,
  parameter int W_LAT [2] = DEF_W_LAT,
  parameter int R_LAT [2] = DEF_R_LAT
) (
  input  logic      clk,
  input  logic      rst_n,
  arb_req_if.slave  req,
  arb_mem_if.master mem
);

  // Zero-length accesses and lengths the counter cannot hold are rejected at elaboration.
  for (genvar p = 0; p < 2; p++) begin : g_lat_chk
    if (W_LAT[p] < 1 || R_LAT[p] < 1 ||
        W_LAT[p] > (1 << LAT_W) || R_LAT[p] > (1 << LAT_W)) begin : g_bad
      $error("mem_port_arbiter: latency out of range on port %0d", p);
    end
  end

  arb_state_t     r_state, w_next;
  port            r_grant, w_winner;
  we_type         r_we;
  logic [A_W-1:0] r_addr;
  logic [D_W-1:0] r_wdata;
  logic [D_W-1:0] r_rdata;
  logic           w_start;
  logic           w_zero;
  int             w_lat;
  logic [LAT_W-1:0] w_load_val;

  assign w_start = (r_state == IDLE) && (req.en != 2'b00);

`ifdef ARB_ROUND_ROBIN_EN
  port r_last_grant;

  // On a tie the port that did not win last time is served.
  always_comb begin
    w_winner = PORTA;
    if (req.en == 2'b11) begin
      w_winner = (r_last_grant == PORTA) ? PORTB : PORTA;
    end else if (req.en[1]) begin
      w_winner = PORTB;
    end
  end

  // Remember every grant; PORTB after reset so PORTA takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PORTB;
    end else if (w_start) begin
      r_last_grant <= w_winner;
    end
  end
`else
  // Fixed priority: PORTA wins whenever it is requesting.
  always_comb begin
    w_winner = req.en[0] ? PORTA : PORTB;
  end
`endif

  // Access length of the winner, picked by its operation type.
  always_comb begin
    w_lat = W_LAT[0];
    if (w_winner == PORTA) begin
      w_lat = req.we[0] ? R_LAT[0] : W_LAT[0];
    end else begin
      w_lat = req.we[1] ? R_LAT[1] : W_LAT[1];
    end
  end

  assign w_load_val = LAT_W'(w_lat - 1);

  lat_counter #(.W(LAT_W)) u_lat_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start),
    .i_load_val (w_load_val),
    .i_dec      (r_state == ACCESS),
    .o_zero     (w_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: grant from IDLE, run out the count in ACCESS, one DONE cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req.en != 2'b00) w_next = ACCESS;
      ACCESS:  if (w_zero) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the winner's request; it drives the memory for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= PORTA;
      r_we    <= WR;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_grant <= w_winner;
      r_we    <= we_type'(req.we[w_winner]);
      r_addr  <= req.addr[w_winner];
      r_wdata <= req.wdata[w_winner];
    end
  end

  // Capture read data on the last ACCESS cycle, when the memory output is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if ((r_state == ACCESS) && w_zero && (r_we == RD)) begin
      r_rdata <= mem.mem_rdata;
    end
  end

  assign mem.mem_en    = (r_state == ACCESS) ? EN_ON : EN_OFF;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

  assign req.ack    = (r_state == DONE) ? {r_grant == PORTB, r_grant == PORTA} : 2'b00;
  assign req.rvalid = req.ack & {2{r_we == RD}};
  assign req.rdata  = r_rdata;
  assign req.grant  = r_grant;
  assign req.busy   = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, randomized run vs. a timing model.
// Latency: n/a.
// Backpressure: requesters hold their request until ack, occasionally withdrawing.
module tb_mem_port_arbiter;
  import param::*;

  localparam int D_W   = DEF_D_W;
  localparam int A_W   = DEF_A_W;
  localparam int DEPTH = 1 << A_W;
  localparam int WL [2] = DEF_W_LAT;
  localparam int RL [2] = DEF_R_LAT;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic mem_reload = 1'b1;
  int   n_tests    = 0;
  int   n_fail     = 0;

  always #5 clk = ~clk;

  arb_req_if #(.D_W(D_W), .A_W(A_W)) req ();
  arb_mem_if #(.D_W(D_W), .A_W(A_W)) mem ();

  mem_port_arbiter #(.D_W(D_W), .A_W(A_W), .W_LAT(DEF_W_LAT), .R_LAT(DEF_R_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .mem   (mem)
  );

  // Behavioural single-port memory array.
  logic [D_W-1:0] tb_mem [DEPTH];
  function automatic logic [D_W-1:0] init_val(input int i);
    return D_W'(i * 37 + 5);
  endfunction
  always @(posedge clk) begin
    if (mem_reload) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_val(i);
    end else if (mem.mem_en && (mem.mem_we == 1'b0)) begin
      tb_mem[mem.mem_addr] <= mem.mem_wdata;
    end
  end
  assign mem.mem_rdata = tb_mem[mem.mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic en, input logic we,
                       input logic [A_W-1:0] a, input logic [D_W-1:0] d);
    req.en[p]    = en;
    req.we[p]    = we;
    req.addr[p]  = a;
    req.wdata[p] = d;
  endtask

  task automatic do_reset(input logic reload);
    rst_n      = 1'b0;
    mem_reload = reload;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    rst_n      = 1'b1;
    mem_reload = 1'b0;
  endtask

  // Directed vectors, port A only: inputs for one edge and the outputs expected after it.
  typedef struct {
    logic en; logic we; logic [A_W-1:0] a; logic [D_W-1:0] d;
    logic [1:0] x_ack; logic [1:0] x_rv; logic x_busy; logic x_men; logic x_mwe;
    logic [A_W-1:0] x_maddr; logic [D_W-1:0] x_mwd; logic [D_W-1:0] x_rdata;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic we, input logic [A_W-1:0] a,
                              input logic [D_W-1:0] d, input logic [1:0] x_ack,
                              input logic [1:0] x_rv, input logic x_busy, input logic x_men,
                              input logic x_mwe, input logic [A_W-1:0] x_maddr,
                              input logic [D_W-1:0] x_mwd, input logic [D_W-1:0] x_rdata);
    vec_t v;
    v.en = en; v.we = we; v.a = a; v.d = d; v.x_ack = x_ack; v.x_rv = x_rv;
    v.x_busy = x_busy; v.x_men = x_men; v.x_mwe = x_mwe; v.x_maddr = x_maddr;
    v.x_mwd = x_mwd; v.x_rdata = x_rdata;
    return v;
  endfunction

  // Reference model: phase = cycles since the grant edge (0 = idle).
  int             m_phase, m_len, m_port, m_last;
  logic           m_we;
  logic [A_W-1:0] m_addr;
  logic [D_W-1:0] m_wd, m_rdata;
  logic [D_W-1:0] ref_mem [DEPTH];
  logic           h_en [2];
  logic           h_we [2];
  logic [A_W-1:0] h_a  [2];
  logic [D_W-1:0] h_d  [2];

  task automatic model_reset();
    m_phase = 0; m_len = 1; m_port = 0; m_last = 1;
    m_we = 1'b0; m_addr = '0; m_wd = '0; m_rdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
  endtask

  function automatic logic [1:0] m_ack();
    if (m_phase == m_len + 1) return (m_port == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step();
    int w;
    if (m_phase == 0) begin
      if (h_en[0] || h_en[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (h_en[0] && h_en[1]) w = (m_last == 0) ? 1 : 0;
        else                    w = h_en[0] ? 0 : 1;
        m_last = w;
`else
        w = h_en[0] ? 0 : 1;
`endif
        m_port  = w;
        m_we    = h_we[w];
        m_addr  = h_a[w];
        m_wd    = h_d[w];
        m_len   = m_we ? RL[w] : WL[w];
        m_phase = 1;
      end
    end else if (m_phase == m_len + 1) begin
      m_phase = 0;
    end else begin
      if (m_phase == m_len) begin
        if (m_we) m_rdata = ref_mem[m_addr];
        else      ref_mem[m_addr] = m_wd;
      end
      m_phase++;
    end
  endtask

  task automatic model_check();
    logic men;
    logic [1:0] xa;
    men = (m_phase >= 1) && (m_phase <= m_len);
    xa  = m_ack();
    chk("rnd_busy", 32'(req.busy), 32'(m_phase != 0));
    chk("rnd_mem_en", 32'(mem.mem_en), 32'(men));
    chk("rnd_ack", 32'(req.ack), 32'(xa));
    chk("rnd_rvalid", 32'(req.rvalid), 32'(m_we ? xa : 2'b00));
    if (m_phase != 0) chk("rnd_grant", 32'(req.grant), 32'(m_port));
    if (men) begin
      chk("rnd_mem_we", 32'(mem.mem_we), 32'(m_we));
      chk("rnd_mem_addr", 32'(mem.mem_addr), 32'(m_addr));
      if (!m_we) chk("rnd_mem_wdata", 32'(mem.mem_wdata), 32'(m_wd));
    end
    if (m_we && (xa != 2'b00)) chk("rnd_rdata", 32'(req.rdata), 32'(m_rdata));
  endtask

  initial begin
    vec_t tv[$];
    int   t_ack, n_men, k;
    logic rv, nr;
    logic [D_W-1:0] rd;
    int   ack_port [4];
    int   ack_t    [4];
    int   ack_gr   [4];
    int   exp_t, exp_p;

    // Reset state
    do_reset(1'b1);
    rst_n = 1'b0;
    tick();
    chk("rst_busy", 32'(req.busy), 32'd0);
    chk("rst_ack", 32'(req.ack), 32'd0);
    chk("rst_rvalid", 32'(req.rvalid), 32'd0);
    chk("rst_rdata", 32'(req.rdata), 32'd0);
    chk("rst_grant", 32'(req.grant), 32'd0);
    chk("rst_mem_en", 32'(mem.mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem.mem_wdata), 32'd0);
    rst_n = 1'b1;

    // Write 0xA5 to addr 3 on A, then read it back on A.
    for (int i = 0; i < WL[0]; i++)
      tv.push_back(mk(1'b1, 1'b0, A_W'(3), 8'hA5, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, A_W'(3), 8'hA5, 8'h00));
    tv.push_back(mk(1'b1, 1'b0, A_W'(3), 8'hA5, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, '0, '0, '0));
    tv.push_back(mk(1'b0, 1'b0, '0, '0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, '0, '0, '0));
    for (int i = 0; i < RL[0]; i++)
      tv.push_back(mk(1'b1, 1'b1, A_W'(3), 8'h00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, A_W'(3), 8'h00, 8'h00));
    tv.push_back(mk(1'b1, 1'b1, A_W'(3), 8'h00, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, '0, '0, 8'hA5));
    tv.push_back(mk(1'b0, 1'b0, '0, '0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, '0, '0, '0));

    foreach (tv[i]) begin
      drive(0, tv[i].en, tv[i].we, tv[i].a, tv[i].d);
      tick();
      chk($sformatf("vec%0d_ack", i), 32'(req.ack), 32'(tv[i].x_ack));
      chk($sformatf("vec%0d_rvalid", i), 32'(req.rvalid), 32'(tv[i].x_rv));
      chk($sformatf("vec%0d_busy", i), 32'(req.busy), 32'(tv[i].x_busy));
      chk($sformatf("vec%0d_mem_en", i), 32'(mem.mem_en), 32'(tv[i].x_men));
      if (tv[i].x_busy) chk($sformatf("vec%0d_grant", i), 32'(req.grant), 32'd0);
      if (tv[i].x_men) begin
        chk($sformatf("vec%0d_mem_we", i), 32'(mem.mem_we), 32'(tv[i].x_mwe));
        chk($sformatf("vec%0d_mem_addr", i), 32'(mem.mem_addr), 32'(tv[i].x_maddr));
        chk($sformatf("vec%0d_mem_wdata", i), 32'(mem.mem_wdata), 32'(tv[i].x_mwd));
      end
      if (tv[i].x_rv != 2'b00) chk($sformatf("vec%0d_rdata", i), 32'(req.rdata), 32'(tv[i].x_rdata));
    end

    // Reset in the third ACCESS cycle, then restart with a full count.
    drive(0, 1'b1, 1'b0, A_W'(5), 8'h3C);
    tick(); tick(); tick();
    chk("mid_access3_mem_en", 32'(mem.mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(req.busy), 32'd0);
    chk("mid_rst_mem_en", 32'(mem.mem_en), 32'd0);
    chk("mid_rst_ack", 32'(req.ack), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem.mem_addr), 32'd0);
    chk("mid_rst_mem_wdata", 32'(mem.mem_wdata), 32'd0);
    @(negedge clk);
    tick();
    chk("mid_rst_hold_ack", 32'(req.ack), 32'd0);
    chk("mid_rst_hold_busy", 32'(req.busy), 32'd0);
    rst_n = 1'b1;
    t_ack = -1; n_men = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (mem.mem_en) begin
        n_men++;
        chk("restart_mem_addr", 32'(mem.mem_addr), 32'd5);
      end
      if (req.ack[0]) begin t_ack = c; break; end
    end
    chk("restart_ack_cycle", 32'(t_ack), 32'(WL[0] + 1));
    chk("restart_mem_en_cycles", 32'(n_men), 32'(WL[0]));
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();

    // B read at addr 7, en dropped after the first ACCESS cycle.
    drive(1, 1'b1, 1'b1, A_W'(7), 8'h00);
    tick();
    chk("drop_grant", 32'(req.grant), 32'd1);
    chk("drop_mem_addr", 32'(mem.mem_addr), 32'd7);
    drive(1, 1'b0, 1'b0, '0, '0);
    t_ack = -1; rv = 1'b0; rd = '0;
    for (int c = 2; c <= 30; c++) begin
      tick();
      if (req.ack[1]) begin t_ack = c; rv = req.rvalid[1]; rd = req.rdata; break; end
    end
    chk("drop_ack_cycle", 32'(t_ack), 32'(RL[1] + 1));
    chk("drop_rvalid", 32'(rv), 32'd1);
    chk("drop_rdata", 32'(rd), 32'(init_val(7)));
    tick();

    // Both ports held requesting continuously.
    do_reset(1'b0);
    drive(0, 1'b1, 1'b0, A_W'(1), 8'h11);
    drive(1, 1'b1, 1'b1, A_W'(2), 8'h00);
    k = 0;
    for (int c = 1; c <= 120 && k < 4; c++) begin
      tick();
      if (req.ack != 2'b00) begin
        ack_port[k] = req.ack[1] ? 1 : 0;
        ack_t[k]    = c;
        ack_gr[k]   = int'(req.grant);
        k++;
      end
    end
    chk("tie_ack_count", 32'(k), 32'd4);
    exp_t = 0;
    for (int i = 0; i < k; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_p = i % 2;
`else
      exp_p = 0;
`endif
      exp_t = exp_t + ((i == 0) ? 1 : 2) + ((exp_p == 1) ? RL[1] : WL[0]) - ((i == 0) ? 0 : 0);
      chk($sformatf("tie%0d_port", i), 32'(ack_port[i]), 32'(exp_p));
      chk($sformatf("tie%0d_grant", i), 32'(ack_gr[i]), 32'(exp_p));
      chk($sformatf("tie%0d_cycle", i), 32'(ack_t[i]), 32'(exp_t));
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick(); tick();

    // Randomized requesters against the model.
    do_reset(1'b1);
    model_reset();
    for (int p = 0; p < 2; p++) begin
      h_en[p] = 1'b0; h_we[p] = 1'b0; h_a[p] = '0; h_d[p] = '0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        nr = 1'b0;
        if (h_en[p]) begin
          if (m_ack()[p]) begin
            h_en[p] = 1'b0;
            nr = 1'($urandom_range(0, 1));
          end else if ($urandom_range(0, 39) == 0) begin
            h_en[p] = 1'b0;
          end
        end else begin
          nr = ($urandom_range(0, 2) == 0);
        end
        if (nr) begin
          h_en[p] = 1'b1;
          h_we[p] = 1'($urandom_range(0, 1));
          h_a[p]  = A_W'($urandom_range(0, DEPTH - 1));
          h_d[p]  = D_W'($urandom);
        end
        drive(p, h_en[p], h_we[p], h_a[p], h_d[p]);
      end
      model_step();
      tick();
      model_check();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
